support_seq: RTL and testbench
==============================

SUPPORT_SEQ -- requirements
Module: support_seq

Interface
REQ-001 Parameters SHALL be (name, default, meaning), one per line:
  NBUTTONS, 4, button count; minimum 4
  DEBOUNCE_BITS, 20, input must be stable 2**DEBOUNCE_BITS cycles to be accepted
  DCM_HOLD, 16, cycles dcm_reset is held per attempt
  LOCK_TIMEOUT, 65535, cycles to wait for lock before retrying
  RESET_HOLD, 1024, cycles cpu_reset is held after lock
  BOOT_CYCLES, 4, boot pulse width in cycles
REQ-002 Ports SHALL be (name, direction, width, meaning), one per line:
  sysclk  in  1  only clock, rising edge
  reset  in  1  synchronous, active-high
  button  in  NBUTTONS  raw asynchronous buttons: [0] reset request, [1] boot, [2] halt toggle, [3] interrupt, [NBUTTONS-1:4] spare
  dcm_locked  in  1  asynchronous lock status from the clock manager
  dcm_reset  out  1  clock-manager reset
  cpu_reset  out  1  CPU reset
  boot  out  1  boot pulse
  halt  out  1  halt level
  interrupt  out  1  one-cycle interrupt pulse
  btn_db  out  NBUTTONS  debounced button levels
  state  out  3  FSM state encoding
  retries  out  8  lock-timeout retry count, saturating

Function
REQ-003 Each button bit and dcm_locked SHALL pass through a 2-flop synchroniser; sync latency is 2 cycles.
REQ-004 Per button: a debounce counter of DEBOUNCE_BITS bits SHALL count while the synced value differs from btn_db and clear when they match; btn_db SHALL flip on the cycle the counter wraps from all-ones.
REQ-005 Button edge events SHALL be defined as 0->1 transitions of btn_db and SHALL last one cycle.
REQ-006 FSM states and encodings SHALL be: S_DCM=0, S_LOCK=1, S_RESET=2, S_BOOT=3, S_RUN=4.
REQ-007 S_DCM: dcm_reset=1 for DCM_HOLD cycles, then go to S_LOCK.
REQ-008 S_LOCK: on synced lock=1, go to S_RESET; after LOCK_TIMEOUT cycles without lock, increment retries (saturate at 255) and go to S_DCM.
REQ-009 S_RESET: hold cycle counter for RESET_HOLD cycles, then go to S_BOOT if boot_req=1, otherwise to S_RUN.
REQ-010 S_BOOT: boot=1 for BOOT_CYCLES cycles, clear boot_req, then go to S_RUN.
REQ-011 cpu_reset SHALL be 1 in S_DCM, S_LOCK and S_RESET, and 0 in S_BOOT and S_RUN.
REQ-012 In S_RESET, S_BOOT and S_RUN, a synced lock=0 SHALL force S_DCM on the next cycle, set boot_req=1 and clear halt; lock loss has priority over all button events.
REQ-013 In S_RUN:
  - reset-button edge: go to S_RESET (warm, boot_req unchanged at 0).
  - boot-button edge: set boot_req=1 and go to S_RESET.
  - both edges in the same cycle: boot wins.
REQ-014 In S_RUN, a halt-button edge SHALL toggle halt; halt SHALL clear on entry to S_RESET or S_DCM.
REQ-015 interrupt SHALL be 1 for exactly one cycle, one cycle after an interrupt-button edge, only in S_RUN; edges in any other state are discarded.
REQ-016 Button edges in states other than S_RUN SHALL be ignored, except that debounce tracking continues.
REQ-017 State counters SHALL reload on every state entry; a counter width of clog2 of the largest parameter is sufficient.

Reset
REQ-018 On reset=1, outputs SHALL take these values on the next edge: state=S_DCM, dcm_reset=1, cpu_reset=1, boot=0, halt=0, interrupt=0, btn_db=0, retries=0, boot_req=1, and all counters and synchronisers cleared.
REQ-019 Reset asserted mid-sequence SHALL abort the sequence and restart at S_DCM with no boot or interrupt glitch.

Verification (DEBOUNCE_BITS=2, DCM_HOLD=4, LOCK_TIMEOUT=20, RESET_HOLD=8, BOOT_CYCLES=2)
REQ-020 Power-up, locked=1 from cycle 0 -> dcm_reset high 4 cycles; cpu_reset falls after 8 hold cycles; boot high 2 cycles; state=4.
REQ-021 locked held 0 -> retries increments every 24 cycles (4 + 20); lock rises -> normal sequence completes with boot.
REQ-022 In S_RUN, button[0] high 10 cycles -> cpu_reset high 8 cycles, no boot pulse. button[1] instead -> cpu_reset high 8 cycles, then boot high 2 cycles.
REQ-023 In S_RUN, button[2] bouncing (toggling every 2 cycles), then stable high -> exactly one halt toggle. Lock dropped while halt=1 -> halt=0, state=0, cold boot after relock.
REQ-024 button[3] pressed in S_RUN -> interrupt high exactly 1 cycle. Pressed during S_RESET -> no interrupt. button[0] and button[1] edges in the same cycle -> boot pulse follows.

Source files
------------

// File: rtl/support_seq_if.sv
// Board support sequencer bus: raw buttons and clock-manager lock in,
// sequencing outputs (resets, boot, halt, interrupt) and status out.
//   master : environment side (drives button/dcm_locked, observes the rest)
//   slave  : sequencer side
interface support_seq_if #(
  parameter int NBUTTONS = 4
) ();
  logic [NBUTTONS-1:0] button;
  logic                dcm_locked;
  logic                dcm_reset;
  logic                cpu_reset;
  logic                boot;
  logic                halt;
  logic                interrupt;
  logic [NBUTTONS-1:0] btn_db;
  logic [2:0]          state;
  logic [7:0]          retries;

  modport master (
    output button, dcm_locked,
    input  dcm_reset, cpu_reset, boot, halt, interrupt, btn_db, state, retries
  );

  modport slave (
    input  button, dcm_locked,
    output dcm_reset, cpu_reset, boot, halt, interrupt, btn_db, state, retries
  );
endinterface

// File: rtl/support_seq.sv
// Board support sequencer: brings up the clock manager, waits for lock
// (retrying on timeout), holds the CPU in reset, optionally pulses boot and
// then runs. Debounced buttons request warm reset, boot, halt toggle and an
// interrupt pulse while running.
// Ports:
//   sysclk : clock, rising edge
//   reset  : synchronous, active-high
//   bus    : support_seq_if.slave
//            in : button[NBUTTONS] ([0] reset, [1] boot, [2] halt, [3] irq),
//                 dcm_locked (asynchronous)
//            out: dcm_reset, cpu_reset, boot, halt, interrupt, btn_db,
//                 state[3], retries[8]
module support_seq #(
  parameter int NBUTTONS      = 4,
  parameter int DEBOUNCE_BITS = 20,
  parameter int DCM_HOLD      = 16,
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int RESET_HOLD    = 1024,
  parameter int BOOT_CYCLES   = 4
) (
  input logic          sysclk,
  input logic          reset,
  support_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_DCM   = 3'd0,
    S_LOCK  = 3'd1,
    S_RESET = 3'd2,
    S_BOOT  = 3'd3,
    S_RUN   = 3'd4
  } state_t;

  localparam int MAX_A = (DCM_HOLD > LOCK_TIMEOUT) ? DCM_HOLD : LOCK_TIMEOUT;
  localparam int MAX_B = (RESET_HOLD > BOOT_CYCLES) ? RESET_HOLD : BOOT_CYCLES;
  localparam int MAXP  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = (MAXP > 1) ? $clog2(MAXP) : 1;

  localparam logic [CW-1:0] DCM_LAST   = CW'(DCM_HOLD - 1);
  localparam logic [CW-1:0] LOCK_LAST  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] RESET_LAST = CW'(RESET_HOLD - 1);
  localparam logic [CW-1:0] BOOT_LAST  = CW'(BOOT_CYCLES - 1);

  // Synchronisers
  logic [NBUTTONS-1:0] btn_s1, btn_s2;
  logic                lock_s1, lock_s2;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      btn_s1  <= '0;
      btn_s2  <= '0;
      lock_s1 <= 1'b0;
      lock_s2 <= 1'b0;
    end else begin
      btn_s1  <= bus.button;
      btn_s2  <= btn_s1;
      lock_s1 <= bus.dcm_locked;
      lock_s2 <= lock_s1;
    end
  end

  // Debounce: level flips only after the synced value has disagreed for
  // 2**DEBOUNCE_BITS consecutive cycles; any agreement restarts the count.
  logic [DEBOUNCE_BITS-1:0] db_cnt [NBUTTONS];
  logic [NBUTTONS-1:0]      btn_db_q;
  logic [3:0]               db_prev;
  logic [3:0]               btn_edge;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NBUTTONS; i++) db_cnt[i] <= '0;
      btn_db_q <= '0;
      db_prev  <= '0;
    end else begin
      for (int unsigned i = 0; i < NBUTTONS; i++) begin
        if (btn_s2[i] != btn_db_q[i]) begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
          if (&db_cnt[i]) btn_db_q[i] <= ~btn_db_q[i];
        end else begin
          db_cnt[i] <= '0;
        end
      end
      db_prev <= btn_db_q[3:0];
    end
  end

  assign btn_edge = btn_db_q[3:0] & ~db_prev;

  // Sequencer FSM
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    retries_q, retries_d;
  logic          boot_req_q, boot_req_d;
  logic          halt_q, halt_d;
  logic          irq_q, irq_d;
  logic          lock_lost;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q    <= S_DCM;
      cnt_q      <= '0;
      retries_q  <= '0;
      boot_req_q <= 1'b1;
      halt_q     <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retries_q  <= retries_d;
      boot_req_q <= boot_req_d;
      halt_q     <= halt_d;
      irq_q      <= irq_d;
    end
  end

  // Lock loss after the clock is up overrides every button event.
  assign lock_lost = !lock_s2 &&
                     (state_q == S_RESET || state_q == S_BOOT || state_q == S_RUN);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    retries_d  = retries_q;
    boot_req_d = boot_req_q;
    halt_d     = halt_q;
    irq_d      = 1'b0;
    if (lock_lost) begin
      state_d    = S_DCM;
      cnt_d      = '0;
      boot_req_d = 1'b1;
      halt_d     = 1'b0;
    end else begin
      case (state_q)
        S_DCM: begin
          if (cnt_q == DCM_LAST) begin
            state_d = S_LOCK;
            cnt_d   = '0;
          end
        end
        S_LOCK: begin
          if (lock_s2) begin
            state_d = S_RESET;
            cnt_d   = '0;
          end else if (cnt_q == LOCK_LAST) begin
            state_d = S_DCM;
            cnt_d   = '0;
            if (retries_q != '1) retries_d = retries_q + 1'b1;
          end
        end
        S_RESET: begin
          if (cnt_q == RESET_LAST) begin
            state_d = boot_req_q ? S_BOOT : S_RUN;
            cnt_d   = '0;
          end
        end
        S_BOOT: begin
          if (cnt_q == BOOT_LAST) begin
            state_d    = S_RUN;
            boot_req_d = 1'b0;
            cnt_d      = '0;
          end
        end
        S_RUN: begin
          cnt_d = '0;
          irq_d = btn_edge[3];
          if (btn_edge[1]) begin
            boot_req_d = 1'b1;
            state_d    = S_RESET;
            halt_d     = 1'b0;
          end else if (btn_edge[0]) begin
            state_d = S_RESET;
            halt_d  = 1'b0;
          end else if (btn_edge[2]) begin
            halt_d = ~halt_q;
          end
        end
        default: begin
          state_d = S_DCM;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign bus.dcm_reset = (state_q == S_DCM);
  assign bus.cpu_reset = (state_q == S_DCM) || (state_q == S_LOCK) || (state_q == S_RESET);
  assign bus.boot      = (state_q == S_BOOT);
  assign bus.halt      = halt_q;
  assign bus.interrupt = irq_q;
  assign bus.btn_db    = btn_db_q;
  assign bus.state     = state_q;
  assign bus.retries   = retries_q;

endmodule

// File: tb/tb_support_seq.sv
module tb_support_seq;
  localparam int NB = 5;
  localparam logic [2:0] ST_DCM = 3'd0, ST_LOCK = 3'd1, ST_RESET = 3'd2,
                         ST_BOOT = 3'd3, ST_RUN = 3'd4;

  logic sysclk = 1'b0;
  logic reset  = 1'b1;

  support_seq_if #(.NBUTTONS(NB)) bus ();

  support_seq #(
    .NBUTTONS(NB), .DEBOUNCE_BITS(2), .DCM_HOLD(4), .LOCK_TIMEOUT(20),
    .RESET_HOLD(8), .BOOT_CYCLES(2)
  ) dut (
    .sysclk(sysclk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 sysclk = ~sysclk;

  // Expected configuration segments: state/halt/retries and how many cycles
  // that configuration must last (0 = not checked).
  typedef struct {
    logic [2:0] st;
    logic       halt;
    logic [7:0] ret;
    int         hold;
  } exp_t;

  exp_t expq[$];
  bit   intq[$];
  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 1'b0;
  bit   rst_applied = 1'b0;
  logic [7:0] r_m = '0;
  logic       halt_m = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic expect_cfg(input logic [2:0] st, input logic h, input logic [7:0] rt, input int hold);
    exp_t e;
    e.st = st; e.halt = h; e.ret = rt; e.hold = hold;
    expq.push_back(e);
  endtask

  function automatic logic [7:0] sat_add(input logic [7:0] r, input int n);
    int s;
    s = int'(r) + n;
    return (s > 255) ? 8'd255 : 8'(s);
  endfunction

  always @(posedge sysclk) rst_applied <= reset;

  // Monitor / scoreboard
  exp_t        cur;
  logic [11:0] cur_obs;
  bit          have_cur = 1'b0;
  int          dur = 0;
  logic        int_prev = 1'b0;

  always @(negedge sysclk) begin
    logic [11:0] obs;
    if (rst_applied)
      check("reset_vals",
            64'({bus.state, bus.halt, bus.retries, bus.boot, bus.interrupt, bus.btn_db, bus.dcm_reset, bus.cpu_reset}),
            64'({3'd0, 1'b0, 8'd0, 1'b0, 1'b0, {NB{1'b0}}, 1'b1, 1'b1}));
    if (mon_en) begin
      obs = {bus.state, bus.halt, bus.retries};
      if (!have_cur || obs !== cur_obs) begin
        if (have_cur && cur.hold != 0)
          check($sformatf("hold_st%0d", cur.st), 64'(dur), 64'(cur.hold));
        check("transition_expected", 64'(expq.size() != 0), 64'd1);
        if (expq.size() != 0) begin
          cur = expq.pop_front();
          check("cfg", 64'(obs), 64'({cur.st, cur.halt, cur.ret}));
        end else begin
          cur.st = obs[11:9]; cur.halt = obs[8]; cur.ret = obs[7:0]; cur.hold = 0;
        end
        cur_obs  = obs;
        have_cur = 1'b1;
        dur      = 1;
      end else begin
        dur++;
      end
      check("decode", 64'({bus.dcm_reset, bus.cpu_reset, bus.boot}),
            64'({cur.st == ST_DCM, cur.st <= ST_RESET, cur.st == ST_BOOT}));
      if (bus.interrupt === 1'b1) begin
        check("irq_width", 64'(int_prev), 64'd0);
        check("irq_expected", 64'(intq.size() != 0), 64'd1);
        if (intq.size() != 0) void'(intq.pop_front());
        check("irq_in_run", 64'(bus.state), 64'(ST_RUN));
      end
    end else begin
      have_cur = 1'b0;
    end
    int_prev = bus.interrupt;
  end

  // Stimulus
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge sysclk);
      #1;
    end
  endtask

  task automatic press(input logic [NB-1:0] m, input int len);
    bus.button = bus.button | m;
    cyc(len);
    bus.button = bus.button & ~m;
  endtask

  task automatic power_up();
    r_m = '0; halt_m = 1'b0;
    expect_cfg(ST_DCM,   1'b0, 8'd0, 4);
    expect_cfg(ST_LOCK,  1'b0, 8'd0, 1);
    expect_cfg(ST_RESET, 1'b0, 8'd0, 8);
    expect_cfg(ST_BOOT,  1'b0, 8'd0, 2);
    expect_cfg(ST_RUN,   1'b0, 8'd0, 0);
    reset  = 1'b0;
    mon_en = 1'b1;
    cyc(30);
  endtask

  task automatic do_reset_btn(input int len);
    halt_m = 1'b0;
    expect_cfg(ST_RESET, 1'b0, r_m, 8);
    expect_cfg(ST_RUN,   1'b0, r_m, 0);
    press(5'b00001, len);
    cyc(30);
  endtask

  task automatic do_boot(input logic [NB-1:0] m, input int len);
    halt_m = 1'b0;
    expect_cfg(ST_RESET, 1'b0, r_m, 8);
    expect_cfg(ST_BOOT,  1'b0, r_m, 2);
    expect_cfg(ST_RUN,   1'b0, r_m, 0);
    press(m, len);
    cyc(30);
  endtask

  task automatic do_halt(input int len);
    halt_m = ~halt_m;
    expect_cfg(ST_RUN, halt_m, r_m, 0);
    press(5'b00100, len);
    cyc(30);
  endtask

  task automatic do_bounce();
    halt_m = ~halt_m;
    expect_cfg(ST_RUN, halt_m, r_m, 0);
    for (int k = 0; k < 6; k++) begin
      bus.button[2] = (k % 2 == 0);
      cyc(2);
    end
    press(5'b00100, 10);
    cyc(30);
  endtask

  task automatic do_irq(input int len);
    intq.push_back(1'b1);
    press(5'b01000, len);
    cyc(30);
  endtask

  task automatic lock_drop_restore();
    halt_m = 1'b0;
    expect_cfg(ST_DCM,   1'b0, r_m, 4);
    expect_cfg(ST_LOCK,  1'b0, r_m, 1);
    expect_cfg(ST_RESET, 1'b0, r_m, 8);
    expect_cfg(ST_BOOT,  1'b0, r_m, 2);
    expect_cfg(ST_RUN,   1'b0, r_m, 0);
    bus.dcm_locked = 1'b0;
    cyc(3);
    bus.dcm_locked = 1'b1;
    cyc(40);
  endtask

  task automatic lock_timeout(input int n);
    halt_m = 1'b0;
    for (int j = 0; j <= n; j++) begin
      expect_cfg(ST_DCM,  1'b0, sat_add(r_m, j), 4);
      expect_cfg(ST_LOCK, 1'b0, sat_add(r_m, j), (j < n) ? 20 : 0);
    end
    r_m = sat_add(r_m, n);
    expect_cfg(ST_RESET, 1'b0, r_m, 8);
    expect_cfg(ST_BOOT,  1'b0, r_m, 2);
    expect_cfg(ST_RUN,   1'b0, r_m, 0);
    bus.dcm_locked = 1'b0;
    cyc(13 + 24 * n);
    bus.dcm_locked = 1'b1;
    cyc(40);
  endtask

  task automatic reset_abort();
    mon_en = 1'b0;
    reset  = 1'b1;
    cyc(3);
    expq.delete();
    intq.delete();
    power_up();
  endtask

  initial begin
    bus.button     = '0;
    bus.dcm_locked = 1'b1;
    reset          = 1'b1;
    cyc(3);
    power_up();

    repeat (14) begin
      int act, len;
      act = int'($urandom_range(0, 6));
      len = int'($urandom_range(8, 14));
      cyc(int'($urandom_range(0, 10)));
      case (act)
        0: do_reset_btn(len);
        1: do_boot(5'b00010, len);
        2: do_boot(5'b00011, len);
        3: do_halt(len);
        4: do_bounce();
        5: do_irq(len);
        default: begin press(5'b10000, len); cyc(30); end
      endcase
    end

    // Lock lost while halted: halt clears, cold boot after relock.
    if (!halt_m) do_halt(10);
    lock_drop_restore();

    // Interrupt button edge lands during S_RESET: discarded.
    halt_m = 1'b0;
    expect_cfg(ST_RESET, 1'b0, r_m, 8);
    expect_cfg(ST_BOOT,  1'b0, r_m, 2);
    expect_cfg(ST_RUN,   1'b0, r_m, 0);
    bus.button[1] = 1'b1;
    cyc(2);
    bus.button[3] = 1'b1;
    cyc(10);
    bus.button = '0;
    cyc(30);

    do_boot(5'b00011, 10);
    do_irq(10);
    lock_timeout(int'($urandom_range(1, 3)));

    // Reset from RUN with halt, retries and a spare level all non-zero.
    if (!halt_m) do_halt(10);
    bus.button[4] = 1'b1;
    cyc(10);
    check("spare_db", 64'(bus.btn_db[4]), 64'd1);
    reset_abort();
    bus.button[4] = 1'b0;
    cyc(10);

    // Reset asserted while the boot pulse is active.
    expect_cfg(ST_RESET, 1'b0, r_m, 8);
    expect_cfg(ST_BOOT,  1'b0, r_m, 2);
    expect_cfg(ST_RUN,   1'b0, r_m, 0);
    bus.button[1] = 1'b1;
    cyc(15);
    bus.button[1] = 1'b0;
    reset_abort();

    // Retry counter saturation.
    lock_timeout(258);

    cyc(5);
    check("expq_drained", 64'(expq.size()), 64'd0);
    check("intq_drained", 64'(intq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
